// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_feeder
// Purpose  : Parallel-to-serial front end for the serial sequence detector.
//            Takes DATA_W-bit words on a valid/ready handshake and emits one
//            bit per clock on bit_out. Back-to-back words leave no gaps. A
//            one-word holding register lets the producer stay a word ahead.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-high; clears all state
//            in_data    - word to serialise
//            in_valid   - in_data valid
//            in_ready   - block can take a word this cycle (= !hold_full)
//            bit_out    - serial bit to the detector (IDLE_BIT when idle)
//            bit_valid  - bit_out carries a data bit this cycle
//            word_done  - high during the last bit of each word
//            busy       - shift register or holding register occupied
//            words_sent - count of fully shifted words, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              word_done,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int                c_cnt_w    = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(DATA_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_full;
    logic                r_bit_out;
    logic                r_bit_valid;
    logic                r_word_done;
    logic                r_busy;
    logic [15:0]         r_words_sent;

    state_t              w_state_n;
    logic [c_cnt_w-1:0]  w_cnt_n;
    logic [DATA_W-1:0]   w_shift_n;
    logic [DATA_W-1:0]   w_hold_n;
    logic                w_hold_full_n;
    logic                w_frees;
    logic                w_accept;
    logic                w_last;
    logic                w_head;

    // The shift register can take a new word when it is empty or when the
    // current word is on its last bit.
    assign w_frees  = (r_state == ST_IDLE) || (r_cnt == c_last_idx);
    assign w_accept = in_valid && !r_hold_full;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == c_last_idx);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_shift_n     = r_shift;
        w_hold_n      = r_hold;
        w_hold_full_n = r_hold_full;
        if (w_frees) begin
            if (r_hold_full) begin
                // in_ready is low here, so no accept can coincide.
                w_state_n     = ST_SHIFT;
                w_cnt_n       = '0;
                w_shift_n     = r_hold;
                w_hold_full_n = 1'b0;
            end else if (w_accept) begin
                w_state_n = ST_SHIFT;
                w_cnt_n   = '0;
                w_shift_n = in_data;
            end else begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
                w_shift_n = '0;
            end
        end else begin
            w_cnt_n = r_cnt + 1'b1;
            if (MSB_FIRST) begin
                w_shift_n = {r_shift[DATA_W-2:0], 1'b0};
            end else begin
                w_shift_n = {1'b0, r_shift[DATA_W-1:1]};
            end
            if (w_accept) begin
                w_hold_n      = in_data;
                w_hold_full_n = 1'b1;
            end
        end
    end

    // The bit presented in the next cycle is the head of the next shift value,
    // so every output can be registered without adding latency.
    assign w_head = MSB_FIRST ? w_shift_n[DATA_W-1] : w_shift_n[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_bit_out    <= IDLE_BIT;
            r_bit_valid  <= 1'b0;
            r_word_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_words_sent <= 16'd0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_shift     <= w_shift_n;
            r_hold      <= w_hold_n;
            r_hold_full <= w_hold_full_n;
            r_bit_valid <= (w_state_n == ST_SHIFT);
            r_bit_out   <= (w_state_n == ST_SHIFT) ? w_head : IDLE_BIT;
            r_word_done <= (w_state_n == ST_SHIFT) && (w_cnt_n == c_last_idx);
            r_busy      <= (w_state_n == ST_SHIFT) || w_hold_full_n;
            if (w_last) begin
                r_words_sent <= r_words_sent + 16'd1;
            end
        end
    end

    assign in_ready   = !r_hold_full;
    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign word_done  = r_word_done;
    assign busy       = r_busy;
    assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_feeder
// Purpose  : Directed self-checking bench for serial_bit_feeder. One MSB-first
//            and one LSB-first instance share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

    logic        clk;
    logic        reset;

    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_bit;
    logic        m_bvalid;
    logic        m_done;
    logic        m_busy;
    logic [15:0] m_words;

    logic [7:0]  l_data;
    logic        l_valid;
    logic        l_ready;
    logic        l_bit;
    logic        l_bvalid;
    logic        l_done;
    logic        l_busy;
    logic [15:0] l_words;

    int n_pass;
    int n_total;

    serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in_data(m_data), .in_valid(m_valid),
        .in_ready(m_ready), .bit_out(m_bit), .bit_valid(m_bvalid),
        .word_done(m_done), .busy(m_busy), .words_sent(m_words)
    );

    serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid),
        .in_ready(l_ready), .bit_out(l_bit), .bit_valid(l_bvalid),
        .word_done(l_done), .busy(l_busy), .words_sent(l_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word for one edge; returns at the negedge showing bit 0.
    task automatic send_m(input logic [7:0] d);
        @(negedge clk);
        m_data  = d;
        m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
    endtask

    task automatic send_l(input logic [7:0] d);
        @(negedge clk);
        l_data  = d;
        l_valid = 1'b1;
        @(negedge clk);
        l_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (m_bvalid !== 1'b0) $display("FAIL rst_bit_valid: got %b want 0", m_bvalid); else n_pass++;
        n_total++; if (m_bit !== 1'b0) $display("FAIL rst_bit_out: got %b want 0", m_bit); else n_pass++;
        n_total++; if (m_done !== 1'b0) $display("FAIL rst_word_done: got %b want 0", m_done); else n_pass++;
        n_total++; if (m_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", m_busy); else n_pass++;
        n_total++; if (m_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", m_ready); else n_pass++;
        n_total++; if (m_words !== 16'd0) $display("FAIL rst_words_sent: got %h want 0000", m_words); else n_pass++;
    endtask

    task automatic test_single_word;
        logic [7:0] exp;
        exp = 8'hA8;
        send_m(exp);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (m_bvalid !== 1'b1) $display("FAIL t1_valid%0d: got %b want 1", i, m_bvalid); else n_pass++;
            n_total++; if (m_bit !== exp[7-i]) $display("FAIL t1_bit%0d: got %b want %b", i, m_bit, exp[7-i]); else n_pass++;
            n_total++; if (m_done !== (i == 7)) $display("FAIL t1_done%0d: got %b want %b", i, m_done, (i == 7)); else n_pass++;
            n_total++; if (m_busy !== 1'b1) $display("FAIL t1_busy%0d: got %b want 1", i, m_busy); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (m_bvalid !== 1'b0) $display("FAIL t1_idle_valid: got %b want 0", m_bvalid); else n_pass++;
        n_total++; if (m_bit !== 1'b0) $display("FAIL t1_idle_bit: got %b want 0", m_bit); else n_pass++;
        n_total++; if (m_busy !== 1'b0) $display("FAIL t1_idle_busy: got %b want 0", m_busy); else n_pass++;
        n_total++; if (m_words !== 16'd1) $display("FAIL t1_words: got %h want 0001", m_words); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  w [3];
        logic [23:0] bits;
        logic        acc;
        logic        started;
        logic        ended;
        logic        gap;
        logic        ready_low;
        int          idx;
        int          nvalid;
        w[0] = 8'hA8; w[1] = 8'h15; w[2] = 8'h40;
        bits = '0; idx = 0; nvalid = 0;
        started = 1'b0; ended = 1'b0; gap = 1'b0; ready_low = 1'b0;
        @(negedge clk);
        m_data  = w[0];
        m_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            acc = m_valid && m_ready;
            if (m_busy && !m_ready) ready_low = 1'b1;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) m_data = w[idx];
                else         m_valid = 1'b0;
            end
            if (m_bvalid) begin
                if (ended) gap = 1'b1;
                bits    = {bits[22:0], m_bit};
                nvalid++;
                started = 1'b1;
            end else if (started) begin
                ended = 1'b1;
            end
        end
        m_valid = 1'b0;
        n_total++; if (nvalid != 24) $display("FAIL t2_nvalid: got %0d want 24", nvalid); else n_pass++;
        n_total++; if (gap !== 1'b0) $display("FAIL t2_gap: got %b want 0", gap); else n_pass++;
        n_total++; if (bits !== 24'hA81540) $display("FAIL t2_bits: got %h want a81540", bits); else n_pass++;
        n_total++; if (ready_low !== 1'b1) $display("FAIL t2_ready_low: got %b want 1", ready_low); else n_pass++;
        n_total++; if (m_words !== 16'd4) $display("FAIL t2_words: got %h want 0004", m_words); else n_pass++;
        n_total++; if (m_busy !== 1'b0) $display("FAIL t2_busy: got %b want 0", m_busy); else n_pass++;
    endtask

    task automatic test_async_reset;
        logic [7:0] exp;
        exp = 8'hFF;
        send_m(exp);
        for (int i = 0; i < 3; i++) begin
            n_total++; if (m_bit !== 1'b1 || m_bvalid !== 1'b1) $display("FAIL t4_bit%0d: got %b/%b want 1/1", i, m_bit, m_bvalid); else n_pass++;
            if (i < 2) @(negedge clk);
        end
        n_total++; if (m_words !== 16'd4) $display("FAIL t4_words_before: got %h want 0004", m_words); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (m_bvalid !== 1'b0) $display("FAIL t4_valid: got %b want 0", m_bvalid); else n_pass++;
        n_total++; if (m_bit !== 1'b0) $display("FAIL t4_bit_out: got %b want 0", m_bit); else n_pass++;
        n_total++; if (m_busy !== 1'b0) $display("FAIL t4_busy: got %b want 0", m_busy); else n_pass++;
        n_total++; if (m_ready !== 1'b1) $display("FAIL t4_ready: got %b want 1", m_ready); else n_pass++;
        n_total++; if (m_words !== 16'd0) $display("FAIL t4_words: got %h want 0000", m_words); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp = 8'h3C;
        send_m(exp);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (m_bvalid !== 1'b1 || m_bit !== exp[7-i]) $display("FAIL t4_clean%0d: got %b/%b want 1/%b", i, m_bvalid, m_bit, exp[7-i]); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (m_bvalid !== 1'b0) $display("FAIL t4_clean_end: got %b want 0", m_bvalid); else n_pass++;
        n_total++; if (m_words !== 16'd1) $display("FAIL t4_clean_words: got %h want 0001", m_words); else n_pass++;
    endtask

    task automatic test_lsb_first;
        logic [7:0] exp;
        exp = 8'b0001_0101;
        send_l(8'h15);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (l_bvalid !== 1'b1) $display("FAIL t3_valid%0d: got %b want 1", i, l_bvalid); else n_pass++;
            n_total++; if (l_bit !== exp[i]) $display("FAIL t3_bit%0d: got %b want %b", i, l_bit, exp[i]); else n_pass++;
            n_total++; if (l_done !== (i == 7)) $display("FAIL t3_done%0d: got %b want %b", i, l_done, (i == 7)); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (l_bvalid !== 1'b0) $display("FAIL t3_end_valid: got %b want 0", l_bvalid); else n_pass++;
        n_total++; if (l_words !== 16'd1) $display("FAIL t3_words: got %h want 0001", l_words); else n_pass++;
    endtask

    task automatic test_same_edge_accept;
        logic [7:0] e1;
        logic [7:0] e2;
        e1 = 8'hA8;
        e2 = 8'h5A;
        send_m(e1);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (m_bit !== e1[7-i]) $display("FAIL t6_w1bit%0d: got %b want %b", i, m_bit, e1[7-i]); else n_pass++;
            if (i == 7) begin
                n_total++; if (m_done !== 1'b1) $display("FAIL t6_w1done: got %b want 1", m_done); else n_pass++;
                n_total++; if (m_ready !== 1'b1) $display("FAIL t6_ready_last: got %b want 1", m_ready); else n_pass++;
                m_data  = e2;
                m_valid = 1'b1;
            end
            @(negedge clk);
        end
        m_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_total++; if (m_bvalid !== 1'b1 || m_bit !== e2[7-j]) $display("FAIL t6_w2bit%0d: got %b/%b want 1/%b", j, m_bvalid, m_bit, e2[7-j]); else n_pass++;
            n_total++; if (m_ready !== 1'b1) $display("FAIL t6_hold%0d: got in_ready %b want 1", j, m_ready); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (m_bvalid !== 1'b0) $display("FAIL t6_end_valid: got %b want 0", m_bvalid); else n_pass++;
        n_total++; if (m_words !== 16'd3) $display("FAIL t6_words: got %h want 0003", m_words); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [7:0] exp;
        exp = 8'h81;
        @(negedge clk);
        force dut_m.r_words_sent = 16'hFFFF;
        #1;
        release dut_m.r_words_sent;
        #1;
        n_total++; if (m_words !== 16'hFFFF) $display("FAIL t5_preload: got %h want ffff", m_words); else n_pass++;
        send_m(exp);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (m_bvalid !== 1'b1 || m_bit !== exp[7-i]) $display("FAIL t5_bit%0d: got %b/%b want 1/%b", i, m_bvalid, m_bit, exp[7-i]); else n_pass++;
            if (i == 7) begin
                n_total++; if (m_words !== 16'hFFFF) $display("FAIL t5_words_last: got %h want ffff", m_words); else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (m_words !== 16'h0000) $display("FAIL t5_wrap: got %h want 0000", m_words); else n_pass++;
        n_total++; if (m_busy !== 1'b0 || m_bvalid !== 1'b0 || m_ready !== 1'b1) $display("FAIL t5_side: got busy %b valid %b ready %b want 0 0 1", m_busy, m_bvalid, m_ready); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        m_data  = 8'h00;
        m_valid = 1'b0;
        l_data  = 8'h00;
        l_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_async_reset();
        test_lsb_first();
        test_same_edge_accept();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
